// File: rtl/upc_display_sequencer.sv
// Sequencer that feeds the UPC seven-segment decoder. It supports manual latching
// and auto cycling, and never lets an undefined code (010, 111) reach the output.
module upc_display_sequencer #(
    parameter int TICK_CYCLES = 50000000,
    parameter int TICK_W      = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode_auto,
    input  logic [2:0] sw_upc,
    input  logic       load,
    input  logic       pause,
    output logic [2:0] upc_out,
    output logic       blank,
    output logic       err,
    output logic [3:0] item_count
);

    typedef enum logic [1:0] {IDLE, MANUAL, AUTO} state_t;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);

    state_t            state, state_nx;
    logic [TICK_W-1:0] timer, timer_nx;
    logic [2:0]        upc_nx;
    logic              blank_nx, err_nx;
    logic [3:0]        count_nx, count_inc;

    function automatic logic is_defined(input logic [2:0] code);
        return (code != 3'b010) && (code != 3'b111);
    endfunction

    // Auto order skips the two undefined codes; anything unexpected restarts at 000.
    function automatic logic [2:0] next_code(input logic [2:0] code);
        case (code)
            3'b000:  return 3'b001;
            3'b001:  return 3'b011;
            3'b011:  return 3'b100;
            3'b100:  return 3'b101;
            3'b101:  return 3'b110;
            default: return 3'b000;
        endcase
    endfunction

    assign count_inc = (item_count == 4'd15) ? item_count : item_count + 4'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            timer      <= '0;
            upc_out    <= 3'b000;
            blank      <= 1'b1;
            err        <= 1'b0;
            item_count <= 4'd0;
        end else begin
            state      <= state_nx;
            timer      <= timer_nx;
            upc_out    <= upc_nx;
            blank      <= blank_nx;
            err        <= err_nx;
            item_count <= count_nx;
        end
    end

    always_comb begin
        state_nx = state;
        timer_nx = timer;
        upc_nx   = upc_out;
        blank_nx = blank;
        err_nx   = 1'b0;
        count_nx = item_count;
        case (state)
            IDLE: begin
                if (mode_auto) begin
                    state_nx = AUTO;
                    upc_nx   = 3'b000;
                    blank_nx = 1'b0;
                    timer_nx = '0;
                end else if (load) begin
                    if (is_defined(sw_upc)) begin
                        state_nx = MANUAL;
                        upc_nx   = sw_upc;
                        blank_nx = 1'b0;
                        count_nx = count_inc;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            MANUAL: begin
                // Mode change wins; a load in the same cycle is dropped silently.
                if (mode_auto) begin
                    state_nx = AUTO;
                    timer_nx = '0;
                end else if (load) begin
                    if (is_defined(sw_upc)) begin
                        upc_nx   = sw_upc;
                        count_nx = count_inc;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            AUTO: begin
                if (!mode_auto) begin
                    state_nx = MANUAL;
                    timer_nx = '0;
                end else if (!pause) begin
                    if (timer == TICK_LAST) begin
                        timer_nx = '0;
                        upc_nx   = next_code(upc_out);
                    end else begin
                        timer_nx = timer + TICK_W'(1);
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                timer_nx = '0;
                upc_nx   = 3'b000;
                blank_nx = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_upc_display_sequencer.sv
// Randomised and directed bench for upc_display_sequencer. Two instances (hold 4 and 1)
// are checked against a sequence-table model that has one copy per instance.
module tb_upc_display_sequencer;

    logic       clk = 1'b0;
    logic       reset, mode_auto, load, pause;
    logic [2:0] sw_upc;
    logic [2:0] upc_a, upc_b;
    logic       blank_a, blank_b, err_a, err_b;
    logic [3:0] cnt_a, cnt_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    upc_display_sequencer #(.TICK_CYCLES(4), .TICK_W(3)) dut_a (
        .clk(clk), .reset(reset), .mode_auto(mode_auto), .sw_upc(sw_upc), .load(load),
        .pause(pause), .upc_out(upc_a), .blank(blank_a), .err(err_a), .item_count(cnt_a));

    upc_display_sequencer #(.TICK_CYCLES(1), .TICK_W(1)) dut_b (
        .clk(clk), .reset(reset), .mode_auto(mode_auto), .sw_upc(sw_upc), .load(load),
        .pause(pause), .upc_out(upc_b), .blank(blank_b), .err(err_b), .item_count(cnt_b));

    // Model: mode 0 = idle, 1 = manual, 2 = auto. The displayed code is a plain integer.
    int seq [6] = '{0, 1, 3, 4, 5, 6};
    int m_mode [2], m_code [2], m_hold [2], m_cnt [2], m_blank [2], m_err [2];
    int tick_len [2] = '{4, 1};

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    function automatic int legal(input int c);
        for (int i = 0; i < 6; i++) if (seq[i] == c) return 1;
        return 0;
    endfunction

    function automatic int after(input int c);
        for (int i = 0; i < 6; i++) if (seq[i] == c) return seq[(i + 1) % 6];
        return 0;
    endfunction

    task automatic model_step(input int k);
        m_err[k] = 0;
        if (reset) begin
            m_mode[k] = 0; m_code[k] = 0; m_blank[k] = 1; m_cnt[k] = 0; m_hold[k] = 0;
        end else if (m_mode[k] == 2) begin
            if (!mode_auto) begin
                m_mode[k] = 1; m_hold[k] = 0;
            end else if (!pause) begin
                m_hold[k]++;
                if (m_hold[k] == tick_len[k]) begin
                    m_hold[k] = 0; m_code[k] = after(m_code[k]);
                end
            end
        end else if (mode_auto) begin
            if (m_mode[k] == 0) begin m_code[k] = 0; m_blank[k] = 0; end
            m_mode[k] = 2; m_hold[k] = 0;
        end else if (load) begin
            if (legal(int'(sw_upc))) begin
                m_mode[k] = 1; m_code[k] = int'(sw_upc); m_blank[k] = 0;
                if (m_cnt[k] < 15) m_cnt[k]++;
            end else begin
                m_err[k] = 1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        chk("upc_a", int'(upc_a), m_code[0]);
        chk("blank_a", int'(blank_a), m_blank[0]);
        chk("err_a", int'(err_a), m_err[0]);
        chk("count_a", int'(cnt_a), m_cnt[0]);
        chk("upc_b", int'(upc_b), m_code[1]);
        chk("blank_b", int'(blank_b), m_blank[1]);
        chk("err_b", int'(err_b), m_err[1]);
        chk("count_b", int'(cnt_b), m_cnt[1]);
        chk("legal_a", legal(int'(upc_a)), 1);
        chk("legal_b", legal(int'(upc_b)), 1);
    endtask

    task automatic drive(input logic r, input logic ma, input logic ld, input logic [2:0] sw,
                         input logic ps, input int n);
        reset = r; mode_auto = ma; load = ld; sw_upc = sw; pause = ps;
        repeat (n) step();
    endtask

    initial begin
        reset = 1'b1; mode_auto = 1'b0; load = 1'b0; sw_upc = 3'b000; pause = 1'b0;
        @(negedge clk);
        drive(1, 0, 0, 3'b000, 0, 2);
        // Fixed expectations for the reset state, independent of the model.
        chk("rst_upc", int'(upc_a), 0);
        chk("rst_blank", int'(blank_a), 1);
        chk("rst_count", int'(cnt_a), 0);
        drive(0, 0, 0, 3'b000, 0, 10);
        drive(0, 0, 1, 3'b101, 0, 1);
        chk("load101", int'(upc_a), 5);
        drive(0, 0, 1, 3'b111, 0, 1);
        chk("err_pulse", int'(err_a), 1);
        drive(0, 0, 0, 3'b000, 0, 1);
        chk("err_clear", int'(err_a), 0);
        drive(1, 0, 0, 3'b000, 0, 1);

        // Auto run from IDLE, with a load mid-hold that must be ignored.
        drive(0, 1, 0, 3'b000, 0, 10);
        drive(0, 1, 1, 3'b011, 0, 1);
        drive(0, 1, 0, 3'b000, 0, 20);
        // Pause after two hold cycles.
        drive(1, 0, 0, 3'b000, 0, 1);
        drive(0, 1, 0, 3'b000, 0, 3);
        drive(0, 1, 0, 3'b000, 1, 6);
        drive(0, 1, 0, 3'b000, 0, 6);

        // Manual at 011, then a mode toggle with a load in the transition cycle.
        drive(0, 0, 0, 3'b000, 0, 1);
        drive(0, 0, 1, 3'b011, 0, 1);
        drive(0, 1, 1, 3'b101, 0, 1);
        drive(0, 1, 0, 3'b000, 0, 5);
        chk("resume_100", int'(upc_a), 4);
        drive(0, 0, 1, 3'b110, 0, 1);
        drive(0, 1, 1, 3'b001, 0, 1);
        drive(0, 0, 0, 3'b000, 0, 2);

        // Saturation, followed by a reset in the middle of an auto hold.
        for (int i = 0; i < 17; i++) drive(0, 0, 1, seq[i % 6][2:0], 0, 1);
        chk("sat15", int'(cnt_a), 15);
        drive(0, 1, 0, 3'b000, 0, 6);
        drive(1, 1, 0, 3'b000, 0, 1);
        chk("midhold_rst", int'(blank_a), 1);

        // Random phase.
        drive(0, 0, 0, 3'b000, 0, 1);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) mode_auto = ~mode_auto;
            reset  = ($urandom_range(0, 99) == 0);
            load   = ($urandom_range(0, 2) == 0);
            sw_upc = 3'($urandom_range(0, 7));
            pause  = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
